// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search core: FSM state encoding,
// S-box depth and the plaintext character class accepted by the checker.
package rc4_pkg;

  localparam int unsigned S_DEPTH = 256;
  localparam logic [7:0]  CHAR_LO = 8'h61;
  localparam logic [7:0]  CHAR_HI = 8'h7A;
  localparam logic [7:0]  CHAR_SP = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA_RI,
    ST_KSA_RJ,
    ST_KSA_WI,
    ST_KSA_WJ,
    ST_PRGA_RI,
    ST_PRGA_RJ,
    ST_PRGA_WI,
    ST_PRGA_WJ,
    ST_PRGA_RF,
    ST_PRGA_XOR,
    ST_NEXT_KEY,
    ST_FOUND,
    ST_EXHAUSTED
  } rc4_state_t;

  function automatic logic is_valid_char(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SP);
  endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Selects key[idx mod KEY_BYTES]; key byte 0 is the most significant byte.
module rc4_key_byte_sel #(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic [7:0]             idx,
  output logic [7:0]             key_byte
);

  int unsigned sel;

  always_comb begin
    sel      = 32'(idx) % KEY_BYTES;
    key_byte = '0;
    for (int unsigned n = 0; n < KEY_BYTES; n++) begin
      if (n == sel) key_byte = key[(KEY_BYTES-1-n)*8 +: 8];
    end
  end

endmodule

// File: rtl/rc4_key_search_core.sv
// Brute-force RC4 key search: per candidate key runs S init, KSA and PRGA
// decryption against a ciphertext ROM, stopping on the first acceptable key.
module rc4_key_search_core
  import rc4_pkg::*;
#(
  parameter int unsigned           KEY_BYTES = 3,
  parameter int unsigned           KEY_BITS  = 22,
  parameter int unsigned           MSG_LEN   = 32,
  parameter logic [KEY_BYTES*8-1:0] KEY_START = '0,
  parameter int unsigned           KEY_STEP  = 1,
  parameter int unsigned           CHECK_EN  = 1
) (
  input  logic                       CLOCK_50,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       stop,
  output logic [7:0]                 s_addr,
  output logic [7:0]                 s_wdata,
  output logic                       s_wren,
  input  logic [7:0]                 s_q,
  output logic [$clog2(MSG_LEN)-1:0] rom_addr,
  input  logic [7:0]                 rom_q,
  output logic [$clog2(MSG_LEN)-1:0] res_addr,
  output logic [7:0]                 res_wdata,
  output logic                       res_wren,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [KEY_BYTES*8-1:0]     key_out,
  output logic [KEY_BYTES*8-1:0]     cur_key
);

  localparam int unsigned KW = KEY_BYTES * 8;
  localparam int unsigned AW = $clog2(MSG_LEN);
  localparam logic [KW-1:0] KEY_MASK = KW'((64'd1 << KEY_BITS) - 64'd1);
  localparam logic [7:0]    I_LAST   = 8'(S_DEPTH - 1);
  localparam logic [AW-1:0] K_LAST   = AW'(MSG_LEN - 1);

  rc4_state_t    state_q, state_d;
  logic [7:0]    i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [AW-1:0] k_q, k_d;
  logic [KW-1:0] cur_key_q, cur_key_d, key_out_q, key_out_d;
  logic          done_q, done_d, found_q, found_d;

  logic [KW-1:0]     key_masked;
  logic [7:0]        key_byte, ksa_j, prga_j, plain;
  logic [KEY_BITS:0] key_sum;

  assign key_masked = cur_key_q & KEY_MASK;

  rc4_key_byte_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
    .key      (key_masked),
    .idx      (i_q),
    .key_byte (key_byte)
  );

  assign ksa_j   = j_q + s_q + key_byte;
  assign prga_j  = j_q + s_q;
  assign plain   = s_q ^ rom_q;
  // Extra top bit detects running past the key space instead of wrapping.
  assign key_sum = {1'b0, cur_key_q[KEY_BITS-1:0]} + (KEY_BITS+1)'(KEY_STEP);

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    si_d      = si_q;
    sj_d      = sj_q;
    cur_key_d = cur_key_q;
    key_out_d = key_out_q;
    done_d    = done_q;
    found_d   = found_q;
    s_addr    = '0;
    s_wdata   = '0;
    s_wren    = 1'b0;
    res_addr  = '0;
    res_wdata = '0;
    res_wren  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_INIT;
          i_d       = '0;
          j_d       = '0;
          k_d       = '0;
          done_d    = 1'b0;
          found_d   = 1'b0;
          key_out_d = '0;
          cur_key_d = KEY_START & KEY_MASK;
        end
      end
      ST_INIT: begin
        s_wren  = 1'b1;
        s_addr  = i_q;
        s_wdata = i_q;
        i_d     = i_q + 8'd1;
        if (i_q == I_LAST) begin
          state_d = ST_KSA_RI;
          j_d     = '0;
        end
      end
      ST_KSA_RI: begin
        s_addr  = i_q;
        state_d = ST_KSA_RJ;
      end
      ST_KSA_RJ: begin
        si_d    = s_q;
        j_d     = ksa_j;
        s_addr  = ksa_j;
        state_d = ST_KSA_WI;
      end
      // s[j] arrives now and goes straight to s[i]; s[i] was captured before
      // either write, so an i==j swap leaves the entry unchanged.
      ST_KSA_WI: begin
        s_wren  = 1'b1;
        s_addr  = i_q;
        s_wdata = s_q;
        state_d = ST_KSA_WJ;
      end
      ST_KSA_WJ: begin
        s_wren  = 1'b1;
        s_addr  = j_q;
        s_wdata = si_q;
        i_d     = i_q + 8'd1;
        if (i_q == I_LAST) begin
          state_d = ST_PRGA_RI;
          j_d     = '0;
          k_d     = '0;
        end else begin
          state_d = ST_KSA_RI;
        end
      end
      ST_PRGA_RI: begin
        i_d     = i_q + 8'd1;
        s_addr  = i_q + 8'd1;
        state_d = ST_PRGA_RJ;
      end
      ST_PRGA_RJ: begin
        si_d    = s_q;
        j_d     = prga_j;
        s_addr  = prga_j;
        state_d = ST_PRGA_WI;
      end
      ST_PRGA_WI: begin
        sj_d    = s_q;
        s_wren  = 1'b1;
        s_addr  = i_q;
        s_wdata = s_q;
        state_d = ST_PRGA_WJ;
      end
      ST_PRGA_WJ: begin
        s_wren  = 1'b1;
        s_addr  = j_q;
        s_wdata = si_q;
        state_d = ST_PRGA_RF;
      end
      ST_PRGA_RF: begin
        s_addr  = si_q + sj_q;
        state_d = ST_PRGA_XOR;
      end
      ST_PRGA_XOR: begin
        res_wren  = 1'b1;
        res_addr  = k_q;
        res_wdata = plain;
        if ((CHECK_EN != 0) && !is_valid_char(plain)) begin
          state_d = ST_NEXT_KEY;
        end else if (k_q == K_LAST) begin
          state_d = ST_FOUND;
        end else begin
          k_d     = k_q + AW'(1);
          state_d = ST_PRGA_RI;
        end
      end
      ST_NEXT_KEY: begin
        if (key_sum[KEY_BITS]) begin
          state_d = ST_EXHAUSTED;
        end else begin
          cur_key_d = KW'(key_sum[KEY_BITS-1:0]);
          i_d       = '0;
          j_d       = '0;
          k_d       = '0;
          state_d   = ST_INIT;
        end
      end
      ST_FOUND: begin
        key_out_d = cur_key_q;
        found_d   = 1'b1;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_EXHAUSTED: begin
        found_d = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a final byte that would have won.
    if (stop && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      done_d    = 1'b1;
      found_d   = 1'b0;
      key_out_d = key_out_q;
      s_wren    = 1'b0;
      res_wren  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      si_q      <= '0;
      sj_q      <= '0;
      cur_key_q <= KEY_START & KEY_MASK;
      key_out_q <= '0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      cur_key_q <= cur_key_d;
      key_out_q <= key_out_d;
      done_q    <= done_d;
      found_q   <= found_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign found    = found_q;
  assign key_out  = key_out_q;
  assign cur_key  = cur_key_q;
  assign rom_addr = k_q;

endmodule

// File: tb/tb_rc4_key_search_core.sv
// Directed bench for rc4_key_search_core: three cores with different
// KEY_START/KEY_STEP/CHECK_EN, each with its own S RAM, ROM and result RAM.
module tb_rc4_key_search_core;

  localparam logic [23:0] START_TAB [3] = '{24'h000247, 24'h000005, 24'h3FFFFE};
  localparam int unsigned STEP_TAB  [3] = '{1, 1, 4};
  localparam int unsigned CHK_TAB   [3] = '{1, 0, 1};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start [3];
  logic        stop  [3];
  logic [7:0]  s_addr [3], s_wdata [3], s_q [3], rom_q [3], res_wdata [3];
  logic        s_wren [3], res_wren [3], busy [3], done [3], found [3];
  logic [4:0]  rom_addr [3], res_addr [3];
  logic [23:0] key_out [3], cur_key [3];

  logic [7:0]  sram [3][256];
  logic [7:0]  rom  [3][32];
  logic [7:0]  res  [3][32];
  int          nres0 [3] = '{0, 0, 0};
  int          nres  [3] = '{0, 0, 0};

  logic [7:0]  m_s  [256];
  logic [7:0]  m_ks [32];
  logic [7:0]  pt1  [32];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rc4_key_search_core #(
      .KEY_BYTES (3),
      .KEY_BITS  (22),
      .MSG_LEN   (32),
      .KEY_START (START_TAB[g]),
      .KEY_STEP  (STEP_TAB[g]),
      .CHECK_EN  (CHK_TAB[g])
    ) u_dut (
      .CLOCK_50  (clk),
      .reset_n   (reset_n),
      .start     (start[g]),
      .stop      (stop[g]),
      .s_addr    (s_addr[g]),
      .s_wdata   (s_wdata[g]),
      .s_wren    (s_wren[g]),
      .s_q       (s_q[g]),
      .rom_addr  (rom_addr[g]),
      .rom_q     (rom_q[g]),
      .res_addr  (res_addr[g]),
      .res_wdata (res_wdata[g]),
      .res_wren  (res_wren[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .found     (found[g]),
      .key_out   (key_out[g]),
      .cur_key   (cur_key[g])
    );
  end

  // Registered-address memories: q reflects the location addressed last cycle.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (s_wren[g]) sram[g][s_addr[g]] <= s_wdata[g];
      s_q[g]   <= sram[g][s_addr[g]];
      rom_q[g] <= rom[g][rom_addr[g]];
      if (res_wren[g]) begin
        res[g][res_addr[g]] <= res_wdata[g];
        nres[g] <= nres[g] + 1;
        if (res_addr[g] == 5'd0) nres0[g] <= nres0[g] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference RC4: KSA over a 3-byte key (MS byte first), then 32 keystream bytes.
  task automatic rc4_model(input logic [23:0] key);
    logic [7:0] i, j, t;
    logic [7:0] kb [3];
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int n = 0; n < 256; n++) m_s[n] = 8'(n);
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      j = j + m_s[n] + kb[n % 3];
      t = m_s[n]; m_s[n] = m_s[j]; m_s[j] = t;
    end
    i = 8'd0;
    j = 8'd0;
    for (int n = 0; n < 32; n++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      t = m_s[i] + m_s[j];
      m_ks[n] = m_s[t];
    end
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, input string tag);
    int n;
    n = 0;
    while (!done[g] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done[g]), 32'd1);
  endtask

  initial begin
    string msg;
    int    base0, base, wcnt;

    reset_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0;
      stop[g]  = 1'b0;
    end

    msg = "attack at dawn the eagle flies x";
    rc4_model(24'h000249);
    for (int k = 0; k < 32; k++) begin
      pt1[k]    = msg[k];
      rom[0][k] = m_ks[k] ^ pt1[k];
      rom[1][k] = 8'(k * 7 + 3);
    end
    rc4_model(24'h3FFFFE);
    rom[2][0] = m_ks[0] ^ 8'h40;
    for (int k = 1; k < 32; k++) rom[2][k] = 8'h55;

    repeat (3) @(negedge clk);
    chk("rst_busy",    32'(busy[0]),    32'd0);
    chk("rst_done",    32'(done[0]),    32'd0);
    chk("rst_found",   32'(found[0]),   32'd0);
    chk("rst_key_out", 32'(key_out[0]), 32'd0);
    chk("rst_s_wren",  32'(s_wren[0]),  32'd0);
    chk("rst_cur_key0", 32'(cur_key[0]), 32'h000247);
    chk("rst_cur_key2", 32'(cur_key[2]), 32'h3FFFFE);
    reset_n = 1'b1;

    // Valid key 0x249 reached after rejecting 0x247 and 0x248
    base0 = nres0[0];
    pulse_start(0);
    chk("t1_busy",    32'(busy[0]),    32'd1);
    chk("t1_cur_key", 32'(cur_key[0]), 32'h000247);
    wait_done(0, 8000, "t1_done");
    chk("t1_found",   32'(found[0]),   32'd1);
    chk("t1_key_out", 32'(key_out[0]), 32'h000249);
    chk("t1_busy_end", 32'(busy[0]),   32'd0);
    chk("t1_keys_tried", 32'(nres0[0] - base0), 32'd3);
    for (int k = 0; k < 32; k++) chk("t1_plain", 32'(res[0][k]), 32'(pt1[k]));
    repeat (5) @(negedge clk);
    chk("t1_done_held", 32'(done[0]), 32'd1);

    // Reset mid-PRGA, then a fresh search reproduces the result
    base0 = nres0[0];
    pulse_start(0);
    chk("t5_done_cleared", 32'(done[0]), 32'd0);
    wcnt = 0;
    while (nres0[0] == base0 && wcnt < 3000) begin
      @(negedge clk);
      wcnt++;
    end
    chk("t5_prga_reached", 32'(nres0[0] != base0), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_busy",    32'(busy[0]),     32'd0);
    chk("t5_rst_done",    32'(done[0]),     32'd0);
    chk("t5_rst_found",   32'(found[0]),    32'd0);
    chk("t5_rst_key_out", 32'(key_out[0]),  32'd0);
    chk("t5_rst_wren",    32'(s_wren[0] | res_wren[0]), 32'd0);
    chk("t5_rst_s_addr",  32'(s_addr[0]),   32'd0);
    chk("t5_rst_cur_key", 32'(cur_key[0]),  32'h000247);
    @(negedge clk);
    reset_n = 1'b1;
    base0 = nres0[0];
    pulse_start(0);
    wait_done(0, 8000, "t5_done");
    chk("t5_found",   32'(found[0]),   32'd1);
    chk("t5_key_out", 32'(key_out[0]), 32'h000249);
    chk("t5_keys_tried", 32'(nres0[0] - base0), 32'd3);

    // CHECK_EN=0 accepts the first key after one full pass
    rc4_model(24'h000005);
    base0 = nres0[1];
    base  = nres[1];
    pulse_start(1);
    wait_done(1, 3000, "t2_done");
    chk("t2_found",   32'(found[1]),   32'd1);
    chk("t2_key_out", 32'(key_out[1]), 32'h000005);
    chk("t2_keys_tried", 32'(nres0[1] - base0), 32'd1);
    chk("t2_bytes",   32'(nres[1] - base), 32'd32);
    wcnt = 0;
    for (int n = 0; n < 256; n++) if (sram[1][n] !== m_s[n]) wcnt++;
    chk("t2_sram_miscount", 32'(wcnt), 32'd0);
    for (int k = 0; k < 32; k++) chk("t2_plain", 32'(res[1][k]), 32'(m_ks[k] ^ rom[1][k]));

    // Abort during KSA of key 5
    pulse_start(1);
    repeat (300) @(negedge clk);
    chk("t4_busy_ksa", 32'(busy[1]), 32'd1);
    stop[1] = 1'b1;
    #1;
    chk("t4_wren_gated", 32'(s_wren[1] | res_wren[1]), 32'd0);
    @(negedge clk);
    chk("t4_done",  32'(done[1]),  32'd1);
    chk("t4_found", 32'(found[1]), 32'd0);
    chk("t4_busy",  32'(busy[1]),  32'd0);
    wcnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) stop[1] = 1'b0;
      @(negedge clk);
      if (s_wren[1] || res_wren[1]) wcnt++;
    end
    chk("t4_wren_after", 32'(wcnt), 32'd0);

    // Last key in range rejected at byte 0 (decodes to 0x40), then exhausted
    base0 = nres0[2];
    base  = nres[2];
    pulse_start(2);
    wait_done(2, 3000, "t3_done");
    chk("t3_found",   32'(found[2]),   32'd0);
    chk("t3_key_out", 32'(key_out[2]), 32'd0);
    chk("t3_busy",    32'(busy[2]),    32'd0);
    chk("t3_keys_tried", 32'(nres0[2] - base0), 32'd1);
    chk("t3_bytes_written", 32'(nres[2] - base), 32'd1);
    chk("t6_byte0", 32'(res[2][0]), 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
